// File: rtl/boa_muldiv_ctl.sv
// boa_muldiv_ctl: sequences M-extension operations onto an external
// zero-latency multiplier and a pipelined divider. Requests and responses
// use valid/ready handshakes. flush is a synchronous abort; rst_n is an
// asynchronous abort.
module boa_muldiv_ctl #(
   parameter int DIV_LATENCY = 1,
   parameter int TAG_W       = 5
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             flush,
   input  logic             req_valid,
   output logic             req_ready,
   input  logic [2:0]       req_op,
   input  logic [31:0]      req_lhs,
   input  logic [31:0]      req_rhs,
   input  logic [TAG_W-1:0] req_tag,
   output logic             resp_valid,
   input  logic             resp_ready,
   output logic [31:0]      resp_data,
   output logic [TAG_W-1:0] resp_tag,
   output logic             busy,
   output logic             mul_u_lhs,
   output logic             mul_u_rhs,
   output logic [31:0]      mul_lhs,
   output logic [31:0]      mul_rhs,
   input  logic [63:0]      mul_res,
   output logic             div_u,
   output logic [31:0]      div_lhs,
   output logic [31:0]      div_rhs,
   input  logic [31:0]      div_res,
   input  logic [31:0]      mod_res
);

   localparam int CNT_W = $clog2(DIV_LATENCY + 1);
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DIV_LATENCY);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   localparam logic [2:0] OP_MUL    = 3'd0;
   localparam logic [2:0] OP_MULH   = 3'd1;
   localparam logic [2:0] OP_MULHSU = 3'd2;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_EXEC = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [2:0]       op_q, op_d;
   logic [31:0]      lhs_q, lhs_d;
   logic [31:0]      rhs_q, rhs_d;
   logic [TAG_W-1:0] tag_q, tag_d;
   logic             u_lhs_q, u_lhs_d;
   logic             u_rhs_q, u_rhs_d;
   logic             div_u_q, div_u_d;
   logic [31:0]      resp_data_q, resp_data_d;
   logic [TAG_W-1:0] resp_tag_q, resp_tag_d;
   logic             accept_s;
   logic [31:0]      result_s;

   // A new request may enter only from IDLE, or from DONE while the held
   // response is being taken; never during EXEC so the divider is not restarted.
   assign req_ready  = !flush && ((state_q == S_IDLE) || ((state_q == S_DONE) && resp_ready));
   assign accept_s   = req_valid && req_ready;
   assign resp_valid = (state_q == S_DONE);
   assign busy       = (state_q != S_IDLE);
   assign resp_data  = resp_data_q;
   assign resp_tag   = resp_tag_q;

   // Datapath ports come straight from the operand registers, which only
   // change on accept, so they are stable through EXEC and hold afterwards.
   assign mul_lhs   = lhs_q;
   assign mul_rhs   = rhs_q;
   assign div_lhs   = lhs_q;
   assign div_rhs   = rhs_q;
   assign mul_u_lhs = u_lhs_q;
   assign mul_u_rhs = u_rhs_q;
   assign div_u     = div_u_q;

   // Result selection for the operation currently in EXEC; divide-by-zero and
   // signed overflow are resolved here without trusting the divider.
   always_comb begin
      result_s = 32'd0;
      if (!op_q[2]) begin
         if (op_q == OP_MUL) begin
            result_s = mul_res[31:0];
         end else begin
            result_s = mul_res[63:32];
         end
      end else if (rhs_q == 32'd0) begin
         result_s = op_q[1] ? lhs_q : 32'hFFFF_FFFF;
      end else if (!op_q[0] && (lhs_q == 32'h8000_0000) && (rhs_q == 32'hFFFF_FFFF)) begin
         result_s = op_q[1] ? 32'd0 : 32'h8000_0000;
      end else begin
         result_s = op_q[1] ? mod_res : div_res;
      end
   end

   // Next-state logic: FSM transitions, latency counter, request capture and
   // response capture, with flush overriding everything.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      op_d        = op_q;
      lhs_d       = lhs_q;
      rhs_d       = rhs_q;
      tag_d       = tag_q;
      u_lhs_d     = u_lhs_q;
      u_rhs_d     = u_rhs_q;
      div_u_d     = div_u_q;
      resp_data_d = resp_data_q;
      resp_tag_d  = resp_tag_q;
      if (flush) begin
         state_d = S_IDLE;
         cnt_d   = '0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (accept_s) begin
                  state_d = S_EXEC;
               end else begin
                  state_d = S_IDLE;
               end
            end
            S_EXEC: begin
               if (cnt_q == '0) begin
                  state_d     = S_DONE;
                  resp_data_d = result_s;
                  resp_tag_d  = tag_q;
               end else begin
                  cnt_d = cnt_q - CNT_ONE;
               end
            end
            S_DONE: begin
               if (resp_ready) begin
                  state_d = accept_s ? S_EXEC : S_IDLE;
               end else begin
                  state_d = S_DONE;
               end
            end
            default: begin
               state_d = S_IDLE;
               cnt_d   = '0;
            end
         endcase
         if (accept_s) begin
            op_d  = req_op;
            lhs_d = req_lhs;
            rhs_d = req_rhs;
            tag_d = req_tag;
            cnt_d = (req_op[2] && (req_rhs != 32'd0)) ? CNT_LOAD : '0;
            case (req_op)
               OP_MULH: begin
                  u_lhs_d = 1'b0;
                  u_rhs_d = 1'b0;
               end
               OP_MULHSU: begin
                  u_lhs_d = 1'b0;
                  u_rhs_d = 1'b1;
               end
               default: begin
                  u_lhs_d = 1'b1;
                  u_rhs_d = 1'b1;
               end
            endcase
            div_u_d = req_op[2] && req_op[0];
         end else begin
            div_u_d = div_u_q;
         end
      end
   end

   // State and datapath registers with asynchronous active-low reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         cnt_q       <= '0;
         op_q        <= 3'd0;
         lhs_q       <= 32'd0;
         rhs_q       <= 32'd0;
         tag_q       <= '0;
         u_lhs_q     <= 1'b0;
         u_rhs_q     <= 1'b0;
         div_u_q     <= 1'b0;
         resp_data_q <= 32'd0;
         resp_tag_q  <= '0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         op_q        <= op_d;
         lhs_q       <= lhs_d;
         rhs_q       <= rhs_d;
         tag_q       <= tag_d;
         u_lhs_q     <= u_lhs_d;
         u_rhs_q     <= u_rhs_d;
         div_u_q     <= div_u_d;
         resp_data_q <= resp_data_d;
         resp_tag_q  <= resp_tag_d;
      end
   end

endmodule

// File: tb/tb_boa_muldiv_ctl.sv
// Directed testbench for boa_muldiv_ctl with DIV_LATENCY=4. Provides a
// behavioural multiplier and a 4-stage pipelined divider model around the DUT.
module tb_boa_muldiv_ctl;

   localparam int DIV_LAT = 4;
   localparam int TAG_W   = 5;

   logic             clk;
   logic             rst_n;
   logic             flush;
   logic             req_valid;
   logic             req_ready;
   logic [2:0]       req_op;
   logic [31:0]      req_lhs;
   logic [31:0]      req_rhs;
   logic [TAG_W-1:0] req_tag;
   logic             resp_valid;
   logic             resp_ready;
   logic [31:0]      resp_data;
   logic [TAG_W-1:0] resp_tag;
   logic             busy;
   logic             mul_u_lhs;
   logic             mul_u_rhs;
   logic [31:0]      mul_lhs;
   logic [31:0]      mul_rhs;
   logic [63:0]      mul_res;
   logic             div_u;
   logic [31:0]      div_lhs;
   logic [31:0]      div_rhs;
   logic [31:0]      div_res;
   logic [31:0]      mod_res;

   int errors = 0;
   int checks = 0;

   boa_muldiv_ctl #(.DIV_LATENCY(DIV_LAT), .TAG_W(TAG_W)) dut (
      .clk(clk), .rst_n(rst_n), .flush(flush),
      .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
      .req_lhs(req_lhs), .req_rhs(req_rhs), .req_tag(req_tag),
      .resp_valid(resp_valid), .resp_ready(resp_ready),
      .resp_data(resp_data), .resp_tag(resp_tag), .busy(busy),
      .mul_u_lhs(mul_u_lhs), .mul_u_rhs(mul_u_rhs),
      .mul_lhs(mul_lhs), .mul_rhs(mul_rhs), .mul_res(mul_res),
      .div_u(div_u), .div_lhs(div_lhs), .div_rhs(div_rhs),
      .div_res(div_res), .mod_res(mod_res)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Zero-latency multiplier model: sign/zero extend each operand to 64 bits.
   logic [63:0] ml_s, mr_s;
   assign ml_s    = mul_u_lhs ? {32'd0, mul_lhs} : {{32{mul_lhs[31]}}, mul_lhs};
   assign mr_s    = mul_u_rhs ? {32'd0, mul_rhs} : {{32{mul_rhs[31]}}, mul_rhs};
   assign mul_res = ml_s * mr_s;

   // Divider model: garbage for divide-by-zero and signed overflow so the
   // controller must resolve those cases itself.
   logic [31:0] dq_s, mq_s;
   always_comb begin
      if (div_rhs == 32'd0) begin
         dq_s = 32'hDEAD_BEEF;
         mq_s = 32'hDEAD_BEEF;
      end else if (!div_u && div_lhs == 32'h8000_0000 && div_rhs == 32'hFFFF_FFFF) begin
         dq_s = 32'h0BAD_0BAD;
         mq_s = 32'h0BAD_0BAD;
      end else if (div_u) begin
         dq_s = div_lhs / div_rhs;
         mq_s = div_lhs % div_rhs;
      end else begin
         dq_s = $signed(div_lhs) / $signed(div_rhs);
         mq_s = $signed(div_lhs) % $signed(div_rhs);
      end
   end

   // Pipeline delay of DIV_LAT cycles on the divider outputs.
   logic [31:0] dpipe [DIV_LAT];
   logic [31:0] mpipe [DIV_LAT];
   always @(posedge clk) begin
      dpipe[0] <= dq_s;
      mpipe[0] <= mq_s;
      for (int i = 1; i < DIV_LAT; i++) begin
         dpipe[i] <= dpipe[i-1];
         mpipe[i] <= mpipe[i-1];
      end
   end
   assign div_res = dpipe[DIV_LAT-1];
   assign mod_res = mpipe[DIV_LAT-1];

   task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%h expected=%h", name, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Waits (bounded) for resp_valid; n = edges after the accept edge.
   task automatic wait_resp(output logic [31:0] d, output logic [TAG_W-1:0] t, output int n);
      n = 0;
      while (resp_valid !== 1'b1 && n < 20) begin
         step();
         n++;
      end
      d = resp_data;
      t = resp_tag;
   endtask

   // Issues one request from IDLE with resp_ready=1 and collects its response.
   task automatic do_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [TAG_W-1:0] tg, output logic [31:0] d,
                        output logic [TAG_W-1:0] t, output int n);
      req_op    = op;
      req_lhs   = a;
      req_rhs   = b;
      req_tag   = tg;
      req_valid = 1'b1;
      step();
      req_valid = 1'b0;
      wait_resp(d, t, n);
      step();
   endtask

   logic [31:0]      d;
   logic [TAG_W-1:0] t;
   int               n;
   logic             seen;

   initial begin
      rst_n = 1'b0; flush = 1'b0; req_valid = 1'b0; req_op = 3'd0;
      req_lhs = 32'd0; req_rhs = 32'd0; req_tag = '0; resp_ready = 1'b0;
      step();
      step();
      // Reset state
      chk("rst resp_valid", resp_valid, 1'b0);
      chk("rst busy", busy, 1'b0);
      chk("rst resp_data", resp_data, 32'd0);
      chk("rst resp_tag", resp_tag, 5'd0);
      chk("rst mul_lhs", mul_lhs, 32'd0);
      chk("rst u_flags", {mul_u_lhs, mul_u_rhs, div_u}, 3'b000);
      chk("rst div_rhs", div_rhs, 32'd0);
      rst_n = 1'b1;
      step();
      chk("rst req_ready", req_ready, 1'b1);

      // MULH -1 * 2, detailed timing
      req_op = 3'd1; req_lhs = 32'hFFFF_FFFF; req_rhs = 32'h0000_0002; req_tag = 5'd3;
      req_valid = 1'b1;
      step();
      req_valid = 1'b0;
      chk("mulh exec busy", busy, 1'b1);
      chk("mulh exec req_ready", req_ready, 1'b0);
      chk("mulh exec resp_valid", resp_valid, 1'b0);
      chk("mulh mul_lhs", mul_lhs, 32'hFFFF_FFFF);
      chk("mulh u_flags", {mul_u_lhs, mul_u_rhs}, 2'b00);
      step();
      chk("mulh resp_valid", resp_valid, 1'b1);
      chk("mulh resp_data", resp_data, 32'hFFFF_FFFF);
      chk("mulh resp_tag", resp_tag, 5'd3);
      resp_ready = 1'b1;
      #1;
      chk("done req_ready", req_ready, 1'b1);
      step();
      chk("idle busy", busy, 1'b0);
      chk("idle resp_valid", resp_valid, 1'b0);

      // Multiply variants
      do_op(3'd3, 32'hFFFF_FFFF, 32'h0000_0002, 5'd4, d, t, n);
      chk("mulhu data", d, 32'h0000_0001);
      chk("mulhu cycles", n, 1);
      do_op(3'd1, 32'h8000_0000, 32'hFFFF_FFFF, 5'd5, d, t, n);
      chk("mulh ovf data", d, 32'h0000_0000);
      do_op(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 5'd6, d, t, n);
      chk("mulhsu data", d, 32'h8000_0000);
      do_op(3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 5'd7, d, t, n);
      chk("mulhu big data", d, 32'h7FFF_FFFF);
      do_op(3'd0, 32'h8000_0001, 32'hFFFF_FFFF, 5'd8, d, t, n);
      chk("mul low data", d, 32'h7FFF_FFFF);
      chk("mul low tag", t, 5'd8);

      // DIV -7 / 2, detailed timing
      req_op = 3'd4; req_lhs = 32'hFFFF_FFF9; req_rhs = 32'd2; req_tag = 5'd9;
      req_valid = 1'b1;
      step();
      req_valid = 1'b0;
      chk("div div_lhs", div_lhs, 32'hFFFF_FFF9);
      chk("div div_u", div_u, 1'b0);
      for (int i = 0; i < 5; i++) begin
         chk("div exec req_ready", {resp_valid, req_ready}, 2'b00);
         step();
      end
      chk("div resp_valid", resp_valid, 1'b1);
      chk("div resp_data", resp_data, 32'hFFFF_FFFD);
      step();
      do_op(3'd6, 32'hFFFF_FFF9, 32'd2, 5'd10, d, t, n);
      chk("rem data", d, 32'hFFFF_FFFF);
      chk("rem cycles", n, 5);
      do_op(3'd5, 32'd100, 32'd7, 5'd11, d, t, n);
      chk("divu data", d, 32'd14);
      do_op(3'd7, 32'd100, 32'd7, 5'd12, d, t, n);
      chk("remu data", d, 32'd2);

      // Divide by zero bypass
      do_op(3'd5, 32'h0000_1234, 32'd0, 5'd13, d, t, n);
      chk("divu0 data", d, 32'hFFFF_FFFF);
      chk("divu0 cycles", n, 1);
      do_op(3'd7, 32'h0000_1234, 32'd0, 5'd14, d, t, n);
      chk("remu0 data", d, 32'h0000_1234);
      chk("remu0 cycles", n, 1);
      do_op(3'd4, 32'h0000_1234, 32'd0, 5'd15, d, t, n);
      chk("div0 data", d, 32'hFFFF_FFFF);
      do_op(3'd6, 32'hFFFF_FF00, 32'd0, 5'd16, d, t, n);
      chk("rem0 data", d, 32'hFFFF_FF00);

      // Signed overflow
      do_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd17, d, t, n);
      chk("div ovf data", d, 32'h8000_0000);
      chk("div ovf cycles", n, 5);
      do_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd18, d, t, n);
      chk("rem ovf data", d, 32'h0000_0000);

      // Response stall, then back-to-back handshake
      resp_ready = 1'b0;
      req_op = 3'd0; req_lhs = 32'd6; req_rhs = 32'd7; req_tag = 5'd19;
      req_valid = 1'b1;
      step();
      req_op = 3'd5; req_lhs = 32'd100; req_rhs = 32'd7; req_tag = 5'd20;
      step();
      for (int i = 0; i < 3; i++) begin
         chk("stall resp_valid", resp_valid, 1'b1);
         chk("stall resp_data", resp_data, 32'd42);
         chk("stall resp_tag", resp_tag, 5'd19);
         chk("stall req_ready", req_ready, 1'b0);
         if (i < 2) begin
            step();
         end else begin
            #0;
         end
      end
      resp_ready = 1'b1;
      #1;
      chk("b2b req_ready", req_ready, 1'b1);
      step();
      req_valid = 1'b0;
      chk("b2b exec state", {busy, resp_valid, req_ready}, 3'b100);
      chk("b2b div_lhs", div_lhs, 32'd100);
      wait_resp(d, t, n);
      chk("b2b data", d, 32'd14);
      chk("b2b tag", t, 5'd20);
      chk("b2b cycles", n, 5);
      step();

      // Flush in the 2nd EXEC cycle of a DIV
      req_op = 3'd4; req_lhs = 32'hFFFF_FFF9; req_rhs = 32'd2; req_tag = 5'd21;
      req_valid = 1'b1;
      step();
      req_valid = 1'b0;
      step();
      flush = 1'b1;
      req_op = 3'd0; req_lhs = 32'd9; req_rhs = 32'd9; req_tag = 5'd22;
      req_valid = 1'b1;
      #1;
      chk("flush req_ready", req_ready, 1'b0);
      step();
      flush = 1'b0;
      req_valid = 1'b0;
      chk("flush idle", {busy, resp_valid}, 2'b00);
      seen = 1'b0;
      for (int i = 0; i < 10; i++) begin
         if (resp_valid === 1'b1) seen = 1'b1;
         step();
      end
      chk("flush no resp", seen, 1'b0);
      do_op(3'd0, 32'd3, 32'd5, 5'd23, d, t, n);
      chk("post flush mul data", d, 32'd15);
      chk("post flush mul tag", t, 5'd23);

      // Asynchronous reset mid-DIV
      req_op = 3'd4; req_lhs = 32'd100; req_rhs = 32'hFFFF_FFF9; req_tag = 5'd24;
      req_valid = 1'b1;
      step();
      req_valid = 1'b0;
      step();
      #2;
      rst_n = 1'b0;
      #1;
      chk("arst busy", busy, 1'b0);
      chk("arst outputs", {resp_valid, resp_data, resp_tag}, 38'd0);
      chk("arst datapath", {div_lhs, div_rhs, mul_lhs}, 96'd0);
      step();
      rst_n = 1'b1;
      seen = 1'b0;
      for (int i = 0; i < 8; i++) begin
         if (resp_valid === 1'b1) seen = 1'b1;
         step();
      end
      chk("arst no resp", seen, 1'b0);
      chk("arst req_ready", req_ready, 1'b1);
      do_op(3'd4, 32'd100, 32'hFFFF_FFF9, 5'd25, d, t, n);
      chk("post arst div data", d, 32'hFFFF_FFF2);
      chk("post arst div tag", t, 5'd25);
      do_op(3'd6, 32'd100, 32'hFFFF_FFF9, 5'd26, d, t, n);
      chk("post arst rem data", d, 32'd2);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
